// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Initiator side of the 4-bit ALU interface. Commands {a,b,op}
//               arrive on a valid/ready port and are buffered in a FIFO. One
//               command at a time is driven onto the combinational ALU through
//               registered alu_a/alu_b/alu_op, the ALU result and flags are
//               captured one cycle later, and responses leave in acceptance
//               order on a valid/ready response port.
// Ports       : clk, rst_n (async, active low)
//               cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op   - command input
//               alu_a/alu_b/alu_op                       - to ALU
//               alu_result/alu_zero/alu_c_out/alu_of     - from ALU
//               rsp_valid/rsp_ready/rsp_result/rsp_flags/rsp_op/rsp_mismatch
//               fifo_count, busy                         - status
// Options     : ALU_CMD_SELFCHK_EN - when defined, an internal reference
//               model flags ALU results that disagree with it (rsp_mismatch).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_c_out,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [2:0]       rsp_op,
  output logic             rsp_mismatch,
  output logic [PTR_W:0]   fifo_count,
  output logic             busy
);

  localparam logic [1:0]       C_IDLE    = 2'd0;
  localparam logic [1:0]       C_ISSUE   = 2'd1;
  localparam logic [1:0]       C_RESP    = 2'd2;
  localparam int               C_ENTRY_W = 11;
  localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [C_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic [1:0]           r_state;
  logic [3:0]           r_alu_a;
  logic [3:0]           r_alu_b;
  logic [2:0]           r_alu_op;
  logic                 r_rsp_valid;
  logic [3:0]           r_rsp_result;
  logic [2:0]           r_rsp_flags;
  logic [2:0]           r_rsp_op;

  logic                 w_full;
  logic                 w_not_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rsp_hs;
  logic [C_ENTRY_W-1:0] w_head;

  // cmd_ready depends only on the registered count: a pop in the same cycle
  // does not open a slot for the incoming command.
  assign w_full      = (r_count == C_FULL);
  assign w_not_empty = (r_count != '0);
  assign w_push      = cmd_valid && !w_full;
  assign w_rsp_hs    = r_rsp_valid && rsp_ready;
  // The only pops are the FSM load steps: from IDLE, or straight out of RESP
  // on the response handshake so back-to-back commands cost two cycles each.
  assign w_pop       = w_not_empty &&
                       ((r_state == C_IDLE) || ((r_state == C_RESP) && w_rsp_hs));
  assign w_head      = r_mem[r_rd_ptr];

  // FIFO storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= C_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_op     <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_not_empty) r_state <= C_ISSUE;
        end
        C_ISSUE: begin
          // ALU inputs have been stable for a full cycle; sample its outputs.
          r_rsp_valid  <= 1'b1;
          r_rsp_result <= alu_result;
          r_rsp_flags  <= {alu_of, alu_c_out, alu_zero};
          r_rsp_op     <= r_alu_op;
          r_state      <= C_RESP;
        end
        C_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_not_empty ? C_ISSUE : C_IDLE;
          end
        end
        default: r_state <= C_IDLE;
      endcase
      // ALU operand registers change only on a pop and otherwise hold the
      // last command.
      if (w_pop) begin
        {r_alu_a, r_alu_b, r_alu_op} <= w_head;
      end
    end
  end

`ifdef ALU_CMD_SELFCHK_EN
  logic [3:0] w_expected;
  logic       r_mismatch;

  always_comb begin
    w_expected = '0;
    case (r_alu_op)
      3'b000: w_expected = r_alu_a + r_alu_b;
      3'b001: w_expected = r_alu_a - r_alu_b;
      3'b010: w_expected = ~r_alu_a;
      3'b011: w_expected = r_alu_a & r_alu_b;
      3'b100: w_expected = r_alu_a | r_alu_b;
      3'b101: w_expected = r_alu_a ^ r_alu_b;
      3'b110: w_expected = {3'b000, ($signed(r_alu_a) < $signed(r_alu_b))};
      3'b111: w_expected = {3'b000, (r_alu_a == r_alu_b)};
    endcase
  end

  // Captured alongside rsp_result and held with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
    end else if (r_state == C_ISSUE) begin
      r_mismatch <= (alu_result != w_expected);
    end else if ((r_state == C_RESP) && w_rsp_hs) begin
      r_mismatch <= 1'b0;
    end
  end

  assign rsp_mismatch = r_mismatch;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign cmd_ready  = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_op     = r_rsp_op;
  assign fifo_count = r_count;
  assign busy       = (r_state != C_IDLE) || w_not_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_issuer
// Description : Self-checking bench for alu_cmd_issuer. Provides a behavioural
//               4-bit ALU, a scoreboard of accepted commands checked against
//               every response handshake, and directed tests with literal
//               expected values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_a = '0;
  logic [3:0]    cmd_b = '0;
  logic [2:0]    cmd_op = '0;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_op;
  logic [3:0]    alu_result;
  logic          alu_zero;
  logic          alu_c_out;
  logic          alu_of;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [3:0]    rsp_result;
  logic [2:0]    rsp_flags;
  logic [2:0]    rsp_op;
  logic          rsp_mismatch;
  logic [PW:0]   fifo_count;
  logic          busy;

  // ALU override used to provoke the self-check
  logic          force_en = 1'b0;
  logic [3:0]    force_val = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rsp = 0;
  int rsp_cyc[$];

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;
  cmd_t q[$];

  alu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_c_out(alu_c_out), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_op(rsp_op),
    .rsp_mismatch(rsp_mismatch),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {of, c_out, zero, result}
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       of;
    c  = 1'b0;
    of = 1'b0;
    r  = '0;
    s  = '0;
    case (op)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[3:0];
        c  = s[4];
        of = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        s  = {1'b0, a} - {1'b0, b};
        r  = s[3:0];
        c  = s[4];
        of = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {3'b000, ($signed(a) < $signed(b))};
      default: r = {3'b000, (a == b)};
    endcase
    return {of, c, (r == 4'd0), r};
  endfunction

  logic [6:0] alu_w;
  always_comb begin
    alu_w      = alu_fn(alu_a, alu_b, alu_op);
    alu_result = force_en ? force_val : alu_w[3:0];
    alu_of     = alu_w[6];
    alu_c_out  = alu_w[5];
    alu_zero   = alu_w[4];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard/compare process: sampled on the falling edge, where the
  // handshakes that complete on the next rising edge are already decided.
  initial begin : monitor
    cmd_t       c;
    cmd_t       nc;
    logic [6:0] e;
    logic [3:0] er;
    logic       emm;
    logic       prev_held;
    logic [10:0] prev_payload;
    prev_held = 1'b0;
    prev_payload = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev_held = 1'b0;
      end else begin
        if (prev_held && rsp_valid)
          chk("rsp_hold_stable", {rsp_result, rsp_flags, rsp_op, rsp_mismatch}, prev_payload);
        if (rsp_valid && rsp_ready) begin
          if (q.size() == 0) begin
            chk("rsp_without_cmd", 32'd1, 32'd0);
          end else begin
            c  = q.pop_front();
            e  = alu_fn(c.a, c.b, c.op);
            er = force_en ? force_val : e[3:0];
`ifdef ALU_CMD_SELFCHK_EN
            emm = (er != e[3:0]);
`else
            emm = 1'b0;
`endif
            chk("sb_result", rsp_result, er);
            chk("sb_flags", rsp_flags, e[6:4]);
            chk("sb_op", rsp_op, c.op);
            chk("sb_mismatch", rsp_mismatch, emm);
          end
          n_rsp++;
          rsp_cyc.push_back(cyc);
        end
        prev_held    = rsp_valid && !rsp_ready;
        prev_payload = {rsp_result, rsp_flags, rsp_op, rsp_mismatch};
        if (cmd_valid && cmd_ready) begin
          nc.a  = cmd_a;
          nc.b  = cmd_b;
          nc.op = cmd_op;
          q.push_back(nc);
        end
      end
    end
  end

  // Issue one command into an empty block and wait for its response.
  task automatic do_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        output logic [3:0] r, output logic [2:0] f, output logic mm);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !rsp_valid; k++) tick();
    chk("rsp_timeout", rsp_valid, 1'b1);
    r  = rsp_result;
    f  = rsp_flags;
    mm = rsp_mismatch;
    tick();
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } vec_t;

  initial begin : stim
    vec_t        fill[6];
    vec_t        rq[4];
    logic [3:0]  r;
    logic [2:0]  f;
    logic        mm;
    int          base;
    logic        exp_mm;

    // Initial reset
    repeat (3) tick();
    #1 rst_n = 1'b1;

    // ---- single add: 0111 + 0001 ----
    cmd_valid = 1'b1; cmd_a = 4'b0111; cmd_b = 4'b0001; cmd_op = 3'b000;
    tick();                               // edge 0: accepted
    cmd_valid = 1'b0;
    chk("add_count_e0", fifo_count, 3'd1);
    chk("add_busy_e0", busy, 1'b1);
    chk("add_valid_e0", rsp_valid, 1'b0);
    tick();                               // edge 1: popped to ALU
    chk("add_alu_a_e1", alu_a, 4'b0111);
    chk("add_alu_b_e1", alu_b, 4'b0001);
    chk("add_count_e1", fifo_count, 3'd0);
    chk("add_valid_e1", rsp_valid, 1'b0);
    tick();                               // edge 2: response
    chk("add_valid_e2", rsp_valid, 1'b1);
    chk("add_result", rsp_result, 4'b1000);
    chk("add_flags", rsp_flags, 3'b100);
    chk("add_op", rsp_op, 3'b000);
    tick();                               // edge 3: handshake done
    chk("add_valid_e3", rsp_valid, 1'b0);
    chk("add_busy_e3", busy, 1'b0);

    // ---- fill with rsp_ready low, then backpressure, then drain ----
    fill[0] = '{4'd3,    4'd4,    3'd0};  // 0111
    fill[1] = '{4'd2,    4'd5,    3'd1};  // 1101
    fill[2] = '{4'b1010, 4'd0,    3'd2};  // 0101
    fill[3] = '{4'b1100, 4'b1010, 3'd3};  // 1000
    fill[4] = '{4'b1100, 4'b1010, 3'd5};  // 0110
    fill[5] = '{4'b1100, 4'b1010, 3'd4};  // refused (FIFO full)
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_a = fill[i].a;
      cmd_b = fill[i].b;
      cmd_op = fill[i].op;
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_cmd_ready", cmd_ready, 1'b0);
    chk("fill_count", fifo_count, 3'd4);
    chk("fill_sb_depth", q.size(), 5);
    repeat (10) tick();
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_result", rsp_result, 4'b0111);
    chk("bp_flags", rsp_flags, 3'b000);
    chk("bp_op", rsp_op, 3'b000);
    chk("bp_no_hs", n_rsp - base, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 30 && (n_rsp - base) < 5; k++) tick();
    chk("drain_count", n_rsp - base, 5);
    for (int k = rsp_cyc.size() - 4; k < rsp_cyc.size(); k++)
      chk("drain_spacing", rsp_cyc[k] - rsp_cyc[k-1], 2);
    repeat (2) tick();
    chk("drain_busy", busy, 1'b0);
    chk("drain_fifo", fifo_count, 3'd0);
    chk("drain_sb_empty", q.size(), 0);

    // ---- compare ops ----
    do_one(4'b1110, 4'b0001, 3'b110, r, f, mm);
    chk("lt_result", r, 4'b0001);
    chk("lt_mismatch", mm, 1'b0);
    do_one(4'b0101, 4'b0101, 3'b111, r, f, mm);
    chk("eq_result", r, 4'b0001);
    chk("eq_mismatch", mm, 1'b0);
    force_en = 1'b1;
    force_val = 4'b0000;
    do_one(4'b0101, 4'b0101, 3'b111, r, f, mm);
`ifdef ALU_CMD_SELFCHK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    chk("eq_forced_result", r, 4'b0000);
    chk("eq_forced_mismatch", mm, exp_mm);
    tick();
    force_en = 1'b0;

    // ---- reset in RESP with 3 queued ----
    rq[0] = '{4'b0011, 4'b0100, 3'd4};
    rq[1] = '{4'd1, 4'd1, 3'd0};
    rq[2] = '{4'd6, 4'd2, 3'd1};
    rq[3] = '{4'd9, 4'd3, 3'd5};
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_a = rq[i].a;
      cmd_b = rq[i].b;
      cmd_op = rq[i].op;
      tick();
    end
    cmd_valid = 1'b0;
    chk("rst_pre_count", fifo_count, 3'd3);
    chk("rst_pre_valid", rsp_valid, 1'b1);
    chk("rst_pre_alu_op", alu_op, 3'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rsp_ready = 1'b1;
    repeat (2) tick();
    #1 rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", rsp_valid, 1'b0);
    chk("post_rst_count", fifo_count, 3'd0);
    chk("post_rst_no_rsp", n_rsp - base, 0);
    do_one(4'b0011, 4'b0011, 3'b001, r, f, mm);
    chk("sub_result", r, 4'b0000);
    chk("sub_flags", f, 3'b001);
    repeat (2) tick();
    chk("final_sb_empty", q.size(), 0);
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the 4-bit ALU interface. It accepts ALU commands (a, b, op) over a valid/ready port and buffers them in a small FIFO. It drives one command at a time onto the combinational ALU's a/b/op inputs, captures result and flags one cycle later, and returns them in order over a valid/ready response port.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
PTR_W, 2, log2(FIFO_DEPTH); pointer width (count width is PTR_W+1).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept; equals !full
cmd_a  input  4  operand a
cmd_b  input  4  operand b
cmd_op  input  3  ALU opcode (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 less-than, 111 equal)
alu_a  output  4  registered operand to ALU
alu_b  output  4  registered operand to ALU
alu_op  output  3  registered opcode to ALU
alu_result  input  4  ALU result (combinational from alu_a/b/op)
alu_zero  input  1  ALU zero flag
alu_c_out  input  1  ALU carry flag
alu_of  input  1  ALU overflow flag
rsp_valid  output  1  response held
rsp_ready  input  1  consumer accepts response
rsp_result  output  4  captured result
rsp_flags  output  3  captured {of, c_out, zero}
rsp_op  output  3  opcode of this response
rsp_mismatch  output  1  self-check error (see Optional Feature)
fifo_count  output  PTR_W+1  FIFO occupancy
busy  output  1  state != IDLE or fifo_count != 0

Behaviour:
- Reset (rst_n low, async): FIFO pointers and count = 0, state = IDLE. alu_a/alu_b/alu_op = 0. rsp_valid = 0. rsp_result/flags/op = 0. rsp_mismatch = 0. Reset is effective immediately and held until release. Reset mid-operation discards all queued and in-flight commands; no response is emitted for them.
- Push: cmd_valid && cmd_ready at an edge writes {a, b, op} at wr_ptr. wr_ptr wraps modulo FIFO_DEPTH.
- full = (count == FIFO_DEPTH); cmd_ready is low when full, even if a pop occurs in the same cycle (no pass-through).
- Pop happens only in the FSM load step and only when count != 0. Simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: if count != 0, pop head into alu_a/b/op and go to ISSUE.
  - ISSUE: ALU inputs stable for a full cycle. At the edge, capture alu_result, {alu_of, alu_c_out, alu_zero} and alu_op into rsp_*, set rsp_valid = 1, go to RESP.
  - RESP: rsp_* held stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid. If count != 0, pop the next command into alu_* and go to ISSUE; else go to IDLE.
- alu_* registers retain their last command while in IDLE/RESP and change only on a pop.
- Latency: a command accepted at edge N into an idle, empty block gives rsp_valid high from edge N+2 (two cycles after acceptance).
- Throughput: one response per 2 cycles with rsp_ready tied high.
- Flags are captured raw for every op; the issuer does not interpret them.
- Ordering: strict FIFO; responses appear in acceptance order.

Optional Feature:
Macro ALU_CMD_SELFCHK_EN.
- Defined: an internal reference model computes the expected 4-bit result from alu_a/alu_b/alu_op in ISSUE:
  - add/sub: low 4 bits.
  - not: ~a.
  - and/or/xor: bitwise.
  - 110: {3'b0, signed(a) < signed(b)}.
  - 111: {3'b0, a == b}.
  - rsp_mismatch is captured with rsp_result: 1 if alu_result != expected. It is held with the response and cleared on handshake.
- Not defined: the model is absent and rsp_mismatch is tied 0.

Test Plan:
- Reset: rst_n low mid-cycle -> immediately rsp_valid=0, fifo_count=0, alu_op=000, cmd_ready=1, busy=0.
- Single add a=0111 b=0001 op=000 accepted at edge 0, rsp_ready=1 -> rsp_valid rises at edge 2 with rsp_result=1000, rsp_flags=100 (of=1), rsp_op=000.
- Fill with rsp_ready=0: 6 back-to-back commands -> first is popped to ALU, 5 accepted total, cmd_ready=0 with fifo_count=4. Then rsp_ready=1 -> 5 responses in order, 2 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles with rsp_valid=1 -> rsp_result/flags/op unchanged. Releasing gives a single handshake.
- Compare ops: a=1110 b=0001 op=110 -> rsp_result=0001; a=0101 b=0101 op=111 -> rsp_result=0001. With ALU_CMD_SELFCHK_EN and alu_result forced to 0000 on the second -> rsp_mismatch=1.
- Reset in RESP with 3 queued -> after release no rsp_valid, fifo_count=0. A new command sub a=0011 b=0011 -> rsp_result=0000, zero flag as driven by ALU.
